// File: rtl/dual_port_ram_ctrl_if.sv
// Bus bundle for dual_port_ram_ctrl: one write port, one registered read port
// and the clear-engine handshake.
interface dual_port_ram_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                      clear_req;
  logic                      busy;
  logic                      wr_en;
  logic [ADDR_WIDTH-1:0]     wr_addr;
  logic [DATA_WIDTH/8-1:0]   wr_be;
  logic [DATA_WIDTH-1:0]     data_in;
  logic                      rd_en;
  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic [DATA_WIDTH-1:0]     data_out;
  logic                      rd_valid;

  modport master (
    output clear_req, wr_en, wr_addr, wr_be, data_in, rd_en, rd_addr,
    input  busy, data_out, rd_valid
  );

  modport slave (
    input  clear_req, wr_en, wr_addr, wr_be, data_in, rd_en, rd_addr,
    output busy, data_out, rd_valid
  );
endinterface

// File: rtl/dual_port_ram_ctrl.sv
// Simple-dual-port RAM with byte enables, registered read, selectable
// read-during-write policy and a clear engine that zeroes the array.
module dual_port_ram_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned RDW_MODE   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dual_port_ram_ctrl_if.slave  bus
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam bit WRITE_FIRST = (RDW_MODE != 0);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [ADDR_WIDTH-1:0]   r_clr_addr;
  logic                    r_busy;
  logic                    r_rd_valid;
  logic [DATA_WIDTH-1:0]   r_data_out;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_mem_we;
  logic [ADDR_WIDTH-1:0]   w_mem_addr;
  logic [NUM_BYTES-1:0]    w_mem_be;
  logic [DATA_WIDTH-1:0]   w_mem_wdata;
  logic                    w_rd_fire;
  logic [DATA_WIDTH-1:0]   w_rd_word;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_CLEAR;
    else        r_state <= w_state_next;
  end

  // Next-state logic; the clear runs until the last address has been written
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_CLEAR: if (r_clr_addr == LAST_ADDR) w_state_next = ST_IDLE;
      ST_IDLE:  if (bus.clear_req)           w_state_next = ST_CLEAR;
      default:  w_state_next = ST_CLEAR;
    endcase
  end

  // Array port steering: clear engine owns the write port while clearing,
  // and a clear request drops any write/read arriving in the same cycle
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_be    = '0;
    w_mem_wdata = '0;
    w_rd_fire   = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_mem_we   = 1'b1;
        w_mem_addr = r_clr_addr;
        w_mem_be   = '1;
      end
      ST_IDLE: begin
        if (!bus.clear_req) begin
          w_mem_we    = bus.wr_en;
          w_mem_addr  = bus.wr_addr;
          w_mem_be    = bus.wr_be;
          w_mem_wdata = bus.data_in;
          w_rd_fire   = bus.rd_en;
        end
      end
      default: ;
    endcase
  end

  // Read word, with same-address forwarding of enabled lanes when write-first
  always_comb begin
    w_rd_word = r_mem[bus.rd_addr];
    if (WRITE_FIRST && w_mem_we && (w_mem_addr == bus.rd_addr)) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (w_mem_be[i]) w_rd_word[8*i +: 8] = w_mem_wdata[8*i +: 8];
      end
    end
  end

  // Storage array; contents are only ever zeroed by the clear engine
  always_ff @(posedge clk) begin
    if (rst_n && w_mem_we) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (w_mem_be[i]) r_mem[w_mem_addr][8*i +: 8] <= w_mem_wdata[8*i +: 8];
      end
    end
  end

  // Clear address, busy flag and registered read port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clr_addr <= '0;
      r_busy     <= 1'b1;
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_busy     <= (w_state_next == ST_CLEAR);
      r_rd_valid <= w_rd_fire;
      if (w_rd_fire) r_data_out <= w_rd_word;
      if (r_state == ST_CLEAR)  r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
      else if (bus.clear_req)   r_clr_addr <= '0;
    end
  end

  assign bus.busy     = r_busy;
  assign bus.rd_valid = r_rd_valid;
  assign bus.data_out = r_data_out;

endmodule

// File: doc/dual_port_ram_ctrl.md
# dual_port_ram_ctrl

Parametrised simple-dual-port RAM (one write port, one read port) with a registered synchronous read, per-byte write enables, a selectable read-during-write policy, and a built-in clear engine. The clear engine zeroes every word after reset or on request. The block is the general on-chip storage element for buffers and register files in the design. It replaces fixed-size, asynchronous-read memories where width, depth or read timing must vary.

## Interface
- DATA_WIDTH, 8, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH words
- RDW_MODE, 0, same-address read-during-write policy: 0 = old data, 1 = new data (write-first)

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- clear_req  in  1  pulse: start zeroing the whole array (honoured only when busy=0)
- busy  out  1  clear engine active; reads and writes ignored while high
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_WIDTH  write address
- wr_be  in  DATA_WIDTH/8  byte enables; bit i controls data_in[8i+7:8i]
- data_in  in  DATA_WIDTH  write data
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_WIDTH  read address
- data_out  out  DATA_WIDTH  registered read data; holds its value until the next accepted read
- rd_valid  out  1  one-cycle pulse, data_out updated this cycle

## Operation
- FSM states: CLEAR, IDLE.
- Reset (rst_n=0 at an edge):
  - state←CLEAR, clr_addr←0, busy←1, data_out←0, rd_valid←0.
  - Memory contents are not reset directly; they are zeroed by the clear engine.
- CLEAR state:
  - Each cycle writes all-zero to clr_addr and increments clr_addr.
  - The cycle that writes address 2**ADDR_WIDTH−1 moves to IDLE and drops busy.
  - wr_en, rd_en and clear_req are ignored; rd_valid stays 0.
- IDLE state:
  - clear_req=1 → state←CLEAR, clr_addr←0, busy←1.
  - If clear_req arrives together with wr_en or rd_en, clear wins; the write and the read are dropped.
- Write, in IDLE with wr_en=1: each byte lane whose wr_be bit is 1 is updated; lanes with wr_be bit 0 keep their value. wr_be=0 is a legal no-op.
- Read, in IDLE with rd_en=1: data_out←mem[rd_addr] and rd_valid←1 at the next edge. rd_en=0 → rd_valid←0 and data_out holds.
- Read-during-write, rd_en and wr_en to the same address in the same cycle:
  - RDW_MODE=0: data_out returns the pre-write word.
  - RDW_MODE=1: data_out returns the merged word, i.e. new bytes in enabled lanes and old bytes elsewhere.
- Different addresses: the read and the write are independent and both complete.
- Address wrap: clr_addr is ADDR_WIDTH+1 bits internally, or terminal detection is used; no address outside 0..2**ADDR_WIDTH−1 is ever written.
- Reset mid-clear: the clear restarts from address 0; the full clear duration applies again.

## Timing
- Clear duration: exactly 2**ADDR_WIDTH cycles.
  - The first rising edge with rst_n=1 writes address 0.
  - busy is low after edge number 2**ADDR_WIDTH.
  - Default configuration: 16 cycles.
- clear_req sampled at edge N: busy=1 after edge N, busy=0 after edge N+2**ADDR_WIDTH.
- Read latency: 1 cycle. rd_en sampled at edge N → data_out/rd_valid valid after edge N.
- Write visible to a different-cycle read: a write at edge N is readable by rd_en sampled at edge N+1.
- Back-to-back reads every cycle are supported; rd_valid stays high continuously.
- No combinational path from any input to any output.

## Test plan
- Reset then idle (default parameters):
  - Hold rst_n=0 for 2 cycles → busy=1, data_out=0x00, rd_valid=0.
  - After release, busy falls after exactly 16 edges.
  - Reading all 16 addresses returns 0x00.
- Write/read sweep: write mem[a]=a^0xA5 for a=0..15, then read back each address → data_out matches, rd_valid pulses one cycle per read, latency 1.
- Byte enables (DATA_WIDTH=32): write 0x11223344 with wr_be=4'hF, then 0xAABBCCDD with wr_be=4'b0101 to the same address → read returns 0x11BB33DD.
- Read-during-write at address 3, which holds 0x5A; write 0xC3:
  - RDW_MODE=0 → data_out=0x5A.
  - RDW_MODE=1 → data_out=0xC3.
  - A following read of address 3 returns 0xC3 in both modes.
- Clear request with a colliding write: fill the memory with 0xFF, then pulse clear_req with wr_en=1 to address 7 in the same cycle:
  - busy stays high for 16 cycles.
  - A read attempted during busy gives rd_valid=0.
  - After the clear, all words read 0x00, including address 7.
- Reset mid-clear: assert rst_n=0 for 1 cycle at clear cycle 9 → busy stays high for a full 16 further cycles; all words read 0x00 afterwards.
